fifo_array_fsm: RTL and testbench

Parametrised control state machine for the FIFO array. It generalises the fixed 8-FIFO controller to NUM_FIFOS channels and a configurable threshold width. It adds a programmable idle-return hysteresis counter and an optional overflow ERROR state. It sits between the configuration interface and the FIFO bank: it latches almost-full/almost-empty thresholds on `init`, drives the FIFO bank reset, and reports whether the array is idle or carrying traffic.

---
 rtl/fifo_array_fsm.sv | 153 +++++++++++++++
 tb/tb_fifo_array_fsm.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_array_fsm.sv
// fifo_array_fsm
//   Control state machine for an array of NUM_FIFOS FIFOs. It latches the
//   almost-full/almost-empty thresholds on init, drives the FIFO bank reset,
//   and reports whether the array is idle or carrying traffic. ACTIVE returns
//   to IDLE only after IDLE_CNT consecutive all-empty cycles.
//
//   Optional feature macro: FSM_ERROR_EN
//     defined   : any full flag seen in IDLE/ACTIVE enters a sticky ERROR state
//     undefined : fulls ignored, ERROR unreachable, error tied low
//
// Ports
//   clk             rising-edge clock
//   reset_L         asynchronous active-low reset
//   init            synchronous init request (latch thresholds, release FIFO reset)
//   High_Threshold  almost-full threshold to latch    [TH_W]
//   Low_Threshold   almost-empty threshold to latch   [TH_W]
//   empties         per-FIFO empty flags              [NUM_FIFOS]
//   fulls           per-FIFO full flags               [NUM_FIFOS]
//   sup_Threshold   latched high threshold            [TH_W]
//   inf_Threshold   latched low threshold             [TH_W]
//   state           one-hot registered state          [5]
//   fifo_reset_L    active-low reset to the FIFO bank
//   idle            high while in IDLE
//   error           high while in ERROR
module fifo_array_fsm #(
  parameter int NUM_FIFOS = 8,
  parameter int TH_W      = 3,
  parameter int IDLE_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 init,
  input  logic [TH_W-1:0]      High_Threshold,
  input  logic [TH_W-1:0]      Low_Threshold,
  input  logic [NUM_FIFOS-1:0] empties,
  input  logic [NUM_FIFOS-1:0] fulls,
  output logic [TH_W-1:0]      sup_Threshold,
  output logic [TH_W-1:0]      inf_Threshold,
  output logic [4:0]           state,
  output logic                 fifo_reset_L,
  output logic                 idle,
  output logic                 error
);

  localparam int CNT_W = $clog2(IDLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CNT - 1);

  typedef enum logic [4:0] {
    S_RESET  = 5'b00001,
    S_INIT   = 5'b00010,
    S_IDLE   = 5'b00100,
    S_ACTIVE = 5'b01000,
    S_ERROR  = 5'b10000
  } state_e;

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [TH_W-1:0]  sup_n, inf_n;
  logic             frst_n, idle_n, error_n;
  logic             all_empty;
  logic             full_hit;

  assign all_empty = &empties;
  assign state     = state_q;

`ifdef FSM_ERROR_EN
  assign full_hit = |fulls;
`else
  logic unused_fulls;
  assign full_hit     = 1'b0;
  assign unused_fulls = ^fulls;
`endif

  // Next-state / next-output logic
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sup_n   = sup_Threshold;
    inf_n   = inf_Threshold;
    frst_n  = fifo_reset_L;

    if (init) begin
      // init overrides every state, including ERROR
      state_n = S_INIT;
      sup_n   = High_Threshold;
      inf_n   = Low_Threshold;
      frst_n  = 1'b1;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        S_RESET: state_n = S_RESET;
        S_INIT: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
        S_IDLE: begin
          cnt_n = '0;
          if (full_hit)        state_n = S_ERROR;
          else if (!all_empty) state_n = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (full_hit) begin
            state_n = S_ERROR;
          end else if (all_empty) begin
            // counter never passes CNT_LAST, so it cannot wrap
            if (cnt_q == CNT_LAST) begin
              state_n = S_IDLE;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_n = '0;
          end
        end
        S_ERROR: state_n = S_ERROR;
        default: begin
          state_n = S_RESET;
          cnt_n   = '0;
        end
      endcase
    end

    idle_n = (state_n == S_IDLE);
`ifdef FSM_ERROR_EN
    error_n = (state_n == S_ERROR);
`else
    error_n = 1'b0;
`endif
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= S_RESET;
      cnt_q         <= '0;
      sup_Threshold <= '0;
      inf_Threshold <= '0;
      fifo_reset_L  <= 1'b0;
      idle          <= 1'b0;
      error         <= 1'b0;
    end else begin
      state_q       <= state_n;
      cnt_q         <= cnt_n;
      sup_Threshold <= sup_n;
      inf_Threshold <= inf_n;
      fifo_reset_L  <= frst_n;
      idle          <= idle_n;
      error         <= error_n;
    end
  end

endmodule

// File: tb/tb_fifo_array_fsm.sv
module tb_fifo_array_fsm;

`ifdef FSM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int IDLE_N = 4;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  // DUT 0: default parameters
  logic       init0;
  logic [2:0] hi0, lo0, sup0, inf0;
  logic [7:0] emp0, full0;
  logic [4:0] state0;
  logic       frst0, idle0, err0;

  fifo_array_fsm #(.NUM_FIFOS(8), .TH_W(3), .IDLE_CNT(IDLE_N)) dut0 (
    .clk(clk), .reset_L(reset_L), .init(init0),
    .High_Threshold(hi0), .Low_Threshold(lo0),
    .empties(emp0), .fulls(full0),
    .sup_Threshold(sup0), .inf_Threshold(inf0),
    .state(state0), .fifo_reset_L(frst0), .idle(idle0), .error(err0)
  );

  // DUT 1: wide configuration with immediate idle return
  logic        init1;
  logic [4:0]  hi1, lo1, sup1, inf1;
  logic [15:0] emp1, full1;
  logic [4:0]  state1;
  logic        frst1, idle1, err1;

  fifo_array_fsm #(.NUM_FIFOS(16), .TH_W(5), .IDLE_CNT(1)) dut1 (
    .clk(clk), .reset_L(reset_L), .init(init1),
    .High_Threshold(hi1), .Low_Threshold(lo1),
    .empties(emp1), .fulls(full1),
    .sup_Threshold(sup1), .inf_Threshold(inf1),
    .state(state1), .fifo_reset_L(frst1), .idle(idle1), .error(err1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model of DUT 0: mode 0..4 = reset, init, idle, active, error;
  // run = length of the current all-empty streak while carrying traffic.
  int       m_mode;
  int       m_run;
  bit [2:0] m_sup, m_inf;
  bit       m_frst;

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_sup = 0; m_inf = 0; m_frst = 0;
  endtask

  task automatic model_step();
    if (!reset_L) begin
      model_reset();
    end else if (init0) begin
      m_mode = 1; m_sup = hi0; m_inf = lo0; m_frst = 1; m_run = 0;
    end else begin
      case (m_mode)
        1: m_mode = 2;
        2: begin
          if (ERR_EN && full0 != 0) m_mode = 4;
          else if (emp0 != 8'hFF) begin m_mode = 3; m_run = 0; end
        end
        3: begin
          if (ERR_EN && full0 != 0) m_mode = 4;
          else if (emp0 == 8'hFF) begin
            m_run = m_run + 1;
            if (m_run == IDLE_N) begin m_mode = 2; m_run = 0; end
          end else m_run = 0;
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [13:0] exp_vec();
    logic [4:0] st;
    st = 5'(1 << m_mode);
    return {st, m_sup, m_inf, m_frst, logic'(m_mode == 2), logic'(m_mode == 4)};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {state0, sup0, inf0, frst0, idle0, err0};
  endfunction

  // One clock: model samples the same inputs the DUTs see, then move to the
  // falling edge where outputs are compared and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_L = 1'b0; init0 = 0; init1 = 0;
    hi0 = 3'd7; lo0 = 3'd7; emp0 = 8'h00; full0 = 8'h00;
    hi1 = 0; lo1 = 0; emp1 = 16'hFFFF; full1 = 0;
    model_reset();
    tick(); tick();
    reset_L = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec() || state0 !== 5'b00001)
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_init_load();
    emp0 = 8'hFF; init0 = 1; hi0 = 3'd6; lo0 = 3'd2;
    tick();
    n_checks++;
    if ({state0, sup0, inf0, frst0} !== {5'b00010, 3'd6, 3'd2, 1'b1} || dut_vec() !== exp_vec())
      $display("FAIL init_load: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    init0 = 0;
    tick();
    n_checks++;
    if ({state0, idle0} !== {5'b00100, 1'b1} || dut_vec() !== exp_vec())
      $display("FAIL init_to_idle: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_hysteresis();
    logic [7:0] seq [9];
    seq = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 9; i++) begin
      emp0 = seq[i];
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec() || state0 !== ((i == 8) ? 5'b00100 : 5'b01000))
        $display("FAIL hysteresis step%0d: got %h want %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reinit();
    emp0 = 8'h00;
    tick();
    init0 = 1; hi0 = 3'd5; lo0 = 3'd1;
    tick();
    n_checks++;
    if ({state0, sup0, inf0} !== {5'b00010, 3'd5, 3'd1} || dut_vec() !== exp_vec())
      $display("FAIL reinit_active: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    init0 = 0;
    tick();
    n_checks++;
    if (state0 !== 5'b00100 || dut_vec() !== exp_vec())
      $display("FAIL reinit_idle: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (state0 !== 5'b01000 || dut_vec() !== exp_vec())
      $display("FAIL reinit_active_again: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_error();
    emp0 = 8'hFF; full0 = 8'h10;
    tick();
    n_checks++;
    if (err0 !== ERR_EN || state0 !== (ERR_EN ? 5'b10000 : 5'b01000) || dut_vec() !== exp_vec())
      $display("FAIL error_entry: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    full0 = 8'h00;
    tick(); tick();
    n_checks++;
    if (dut_vec() !== exp_vec() || frst0 !== 1'b1 || sup0 !== 3'd5)
      $display("FAIL error_sticky: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
    init0 = 1;
    tick();
    init0 = 0;
    n_checks++;
    if ({state0, err0} !== {5'b00010, 1'b0} || dut_vec() !== exp_vec())
      $display("FAIL error_exit_init: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] clr;
    for (int i = 0; i < 300; i++) begin
      init0 = ($urandom_range(0, 15) == 0);
      hi0   = 3'($urandom);
      lo0   = 3'($urandom);
      clr   = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      emp0  = 8'hFF & ~clr;
      full0 = ($urandom_range(0, 39) == 0) ? 8'($urandom) : 8'h00;
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    init0 = 0; full0 = 0;
  endtask

  task automatic test_async_reset();
    init0 = 1; hi0 = 3'd3; lo0 = 3'd4; emp0 = 8'h00;
    tick();
    init0 = 0;
    tick(); tick();
    #2 reset_L = 1'b0;
    #1;
    n_checks++;
    if ({state0, frst0, sup0, idle0} !== {5'b00001, 1'b0, 3'd0, 1'b0})
      $display("FAIL async_reset: got state %b frst %b sup %0d", state0, frst0, sup0);
    else n_pass++;
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec() || state0 !== 5'b00001)
      $display("FAIL reset_release: got %h want %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_param();
    init1 = 1; hi1 = 5'd31; lo1 = 5'd7; emp1 = 16'hFFFF;
    tick();
    init1 = 0;
    n_checks++;
    if ({state1, sup1, inf1, frst1} !== {5'b00010, 5'd31, 5'd7, 1'b1})
      $display("FAIL param_init: got state %b sup %0d inf %0d", state1, sup1, inf1);
    else n_pass++;
    tick();
    n_checks++;
    if ({state1, idle1} !== {5'b00100, 1'b1})
      $display("FAIL param_idle: got %b want 00100", state1);
    else n_pass++;
    emp1 = 16'h7FFF;
    tick();
    n_checks++;
    if ({state1, idle1} !== {5'b01000, 1'b0})
      $display("FAIL param_active: got %b want 01000", state1);
    else n_pass++;
    emp1 = 16'hFFFF;
    tick();
    n_checks++;
    if ({state1, idle1, err1} !== {5'b00100, 1'b1, 1'b0})
      $display("FAIL param_return: got %b want 00100", state1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_init_load();
    test_hysteresis();
    test_reinit();
    test_error();
    test_random();
    test_async_reset();
    test_param();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
